mode_buffer: RTL and testbench

Parametrised elastic buffer with a compile-time selectable ordering mode: first-in-first-out or last-in-first-out. It generalises the team's generic-module pattern from fixed, stateless specialisations to a stateful storage block. Data width, depth and mode are chosen per instance. It sits between any valid/ready producer and consumer in the design, for rate decoupling (FIFO) or for return-address/undo stacks (LIFO).

---
 rtl/buffer_pkg.sv | 14 +
 rtl/mode_buffer_ptr_counter.sv | 37 +++
 rtl/mode_buffer.sv | 102 ++++++++++
 tb/tb_mode_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared types for the mode-selectable elastic buffer.
// Pick the ordering mode per instance; count width is sized to hold 0..DEPTH.
package buffer_pkg;

  typedef enum logic {
    BufMode_FIFO = 1'b0,
    BufMode_LIFO = 1'b1
  } BufMode;

  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mode_buffer_ptr_counter.sv
// Wrapping up-counter used as a FIFO read or write pointer.
// Wraps at MAX-1 explicitly, so MAX need not be a power of two.
module ptr_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Clear wins over increment so a flush always lands on slot zero.
  always_comb begin
    value_d = value_q;
    if (i_clear) begin
      value_d = '0;
    end else if (i_inc) begin
      value_d = (value_q == W'(MAX - 1)) ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_value = value_q;

endmodule

// File: rtl/mode_buffer.sv
// Elastic valid/ready buffer, FIFO or LIFO ordering chosen per instance.
// All outputs come from registered count, pointers and storage only.
module mode_buffer
  import buffer_pkg::*;
#(
  parameter int     WIDTH = 8,
  parameter int     DEPTH = 4,
  parameter BufMode MODE  = BufMode_FIFO
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clear,
  input  logic                         i_push_valid,
  output logic                         o_push_ready,
  input  logic [WIDTH-1:0]             i_push_data,
  output logic                         o_pop_valid,
  input  logic                         i_pop_ready,
  output logic [WIDTH-1:0]             o_pop_data,
  output logic [countWidth(DEPTH)-1:0] o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int CW = countWidth(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrAddr;
  logic [AW-1:0]    rdAddr;
  logic             pushFire;
  logic             popFire;

  assign o_full       = (count_q == CW'(DEPTH));
  assign o_empty      = (count_q == '0);
  assign o_push_ready = !o_full;
  assign o_pop_valid  = !o_empty;
  assign o_count      = count_q;
  assign o_pop_data   = mem_q[rdAddr];

  assign pushFire = i_push_valid && !o_full;
  assign popFire  = i_pop_ready && !o_empty;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else begin
      case ({pushFire, popFire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only occupancy decides what is visible.
  always_ff @(posedge i_clk) begin
    if (pushFire && !i_clear) begin
      mem_q[wrAddr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    assert (DEPTH >= 2 && WIDTH >= 1);
  end

  if (MODE == BufMode_FIFO) begin : gFifo
    ptr_counter #(.MAX(DEPTH), .W(AW)) uWrPtr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_clear),
      .i_inc   (pushFire),
      .o_value (wrAddr)
    );

    ptr_counter #(.MAX(DEPTH), .W(AW)) uRdPtr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_clear),
      .i_inc   (popFire),
      .o_value (rdAddr)
    );
  end else begin : gLifo
    logic [AW-1:0] topAddr;

    // On a simultaneous push and pop the new entry replaces the top being popped.
    assign topAddr = o_empty ? '0 : AW'(count_q - CW'(1));
    assign rdAddr  = topAddr;
    assign wrAddr  = popFire ? topAddr : AW'(count_q);
  end

endmodule

// File: tb/tb_mode_buffer.sv
// Scoreboard bench for mode_buffer: two FIFO instances (depth 4 and 3) and one LIFO.
// Stimulus queues hand-computed pop data; a negedge monitor checks every pop.
module tb_mode_buffer;
  import buffer_pkg::*;

  logic       clk;
  logic       rst;
  logic       pushValid [3];
  logic [7:0] pushData  [3];
  logic       popReady  [3];
  logic       clear     [3];

  logic       pushReady0, popValid0, full0, empty0;
  logic       pushReady1, popValid1, full1, empty1;
  logic       pushReady2, popValid2, full2, empty2;
  logic [7:0] popData0, popData1, popData2;
  logic [2:0] cnt0, cnt2;
  logic [1:0] cnt1;

  logic [7:0] expQ [3][$];
  int         nVectors;
  int         nMiscompares;

  mode_buffer #(.WIDTH(8), .DEPTH(4), .MODE(BufMode_FIFO)) uFifo4 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear[0]),
    .i_push_valid(pushValid[0]), .o_push_ready(pushReady0), .i_push_data(pushData[0]),
    .o_pop_valid(popValid0), .i_pop_ready(popReady[0]), .o_pop_data(popData0),
    .o_count(cnt0), .o_full(full0), .o_empty(empty0)
  );

  mode_buffer #(.WIDTH(8), .DEPTH(3), .MODE(BufMode_FIFO)) uFifo3 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear[1]),
    .i_push_valid(pushValid[1]), .o_push_ready(pushReady1), .i_push_data(pushData[1]),
    .o_pop_valid(popValid1), .i_pop_ready(popReady[1]), .o_pop_data(popData1),
    .o_count(cnt1), .o_full(full1), .o_empty(empty1)
  );

  mode_buffer #(.WIDTH(8), .DEPTH(4), .MODE(BufMode_LIFO)) uLifo4 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear[2]),
    .i_push_valid(pushValid[2]), .o_push_ready(pushReady2), .i_push_data(pushData[2]),
    .o_pop_valid(popValid2), .i_pop_ready(popReady[2]), .o_pop_data(popData2),
    .o_count(cnt2), .o_full(full2), .o_empty(empty2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] statusOf(input int idx);
    case (idx)
      0:       return {cnt0, full0, empty0, pushReady0, popValid0};
      1:       return {1'b0, cnt1, full1, empty1, pushReady1, popValid1};
      default: return {cnt2, full2, empty2, pushReady2, popValid2};
    endcase
  endfunction

  function automatic logic popValidOf(input int idx);
    case (idx)
      0:       return popValid0;
      1:       return popValid1;
      default: return popValid2;
    endcase
  endfunction

  function automatic logic [7:0] popDataOf(input int idx);
    case (idx)
      0:       return popData0;
      1:       return popData1;
      default: return popData2;
    endcase
  endfunction

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      pushValid[i] = 1'b0;
      pushData[i]  = 8'h00;
      popReady[i]  = 1'b0;
      clear[i]     = 1'b0;
    end
  endtask

  // One clock of stimulus on one instance; expected pop data is queued up front.
  task automatic applyStimulus(input int idx, input logic pv, input logic [7:0] pd,
                               input logic pr, input logic clr,
                               input logic hasExp, input logic [7:0] expData);
    idle();
    pushValid[idx] = pv;
    pushData[idx]  = pd;
    popReady[idx]  = pr;
    clear[idx]     = clr;
    if (hasExp) expQ[idx].push_back(expData);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    applyStimulus(idx, 1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop(input int idx, input logic [7:0] e);
    applyStimulus(idx, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, e);
  endtask

  task automatic pushPop(input int idx, input logic [7:0] d, input logic [7:0] e);
    applyStimulus(idx, 1'b1, d, 1'b1, 1'b0, 1'b1, e);
  endtask

  task automatic checkOutput(input int idx, input string name, input int expCount,
                             input logic expFull, input logic expEmpty);
    logic [6:0] act;
    logic [6:0] req;
    act = statusOf(idx);
    req = {3'(expCount), expFull, expEmpty, !expFull, !expEmpty};
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("[TB] FAIL %s (dut %0d): got cnt=%0d full=%b empty=%b rdy=%b vld=%b, want cnt=%0d full=%b empty=%b rdy=%b vld=%b",
               name, idx, act[6:4], act[3], act[2], act[1], act[0],
               req[6:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // Monitor: every pop that will fire at the next edge is checked against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (popValidOf(i) && popReady[i] && !clear[i]) begin
          nVectors++;
          if (expQ[i].size() == 0) begin
            nMiscompares++;
            $display("[TB] FAIL unexpectedPop (dut %0d): got data=%02h, want no pop", i, popDataOf(i));
          end else begin
            logic [7:0] e;
            e = expQ[i].pop_front();
            if (popDataOf(i) !== e) begin
              nMiscompares++;
              $display("[TB] FAIL popData (dut %0d): got %02h, want %02h", i, popDataOf(i), e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    nMiscompares++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(0, "reset", 0, 1'b0, 1'b1);
    checkOutput(1, "reset", 0, 1'b0, 1'b1);
    checkOutput(2, "reset", 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of traffic.
    push(0, 8'h55);
    push(0, 8'h66);
    checkOutput(0, "preReset", 2, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput(0, "rstAsync", 0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    checkOutput(0, "fifoThree", 3, 1'b0, 1'b0);
    pop(0, 8'h11);
    pop(0, 8'h22);
    pop(0, 8'h33);
    checkOutput(0, "fifoDrained", 0, 1'b0, 1'b1);

    // No bypass: data pushed into an empty buffer is invisible until after the edge.
    pushValid[0] = 1'b1;
    pushData[0]  = 8'h77;
    #1;
    checkOutput(0, "noBypassSame", 0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    idle();
    checkOutput(0, "noBypassNext", 1, 1'b0, 1'b0);
    pop(0, 8'h77);

    for (int i = 0; i < 10; i++) push(0, 8'(8'hA0 + i));
    checkOutput(0, "backpressure", 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pop(0, 8'(8'hA0 + i));
    checkOutput(0, "bpDrained", 0, 1'b0, 1'b1);

    push(0, 8'h21);
    push(0, 8'h22);
    checkOutput(0, "preClear", 2, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput(0, "clearFifo", 0, 1'b0, 1'b1);
    push(0, 8'h31);
    pop(0, 8'h31);
    checkOutput(0, "postClear", 0, 1'b0, 1'b1);

    // Depth-3 FIFO: full rejection, no pass-through when full, pointers wrap twice.
    push(1, 8'h01);
    push(1, 8'h02);
    push(1, 8'h03);
    checkOutput(1, "fifo3Full", 3, 1'b1, 1'b0);
    push(1, 8'h04);
    checkOutput(1, "fullReject", 3, 1'b1, 1'b0);
    pushPop(1, 8'h04, 8'h01);
    checkOutput(1, "noPassThru", 2, 1'b0, 1'b0);
    pushPop(1, 8'h05, 8'h02);
    pushPop(1, 8'h06, 8'h03);
    pushPop(1, 8'h07, 8'h05);
    pushPop(1, 8'h08, 8'h06);
    pushPop(1, 8'h09, 8'h07);
    checkOutput(1, "wrapSteady", 2, 1'b0, 1'b0);
    pop(1, 8'h08);
    pop(1, 8'h09);
    checkOutput(1, "wrapDrained", 0, 1'b0, 1'b1);

    push(2, 8'h0A);
    push(2, 8'h0B);
    push(2, 8'h0C);
    checkOutput(2, "lifoThree", 3, 1'b0, 1'b0);
    pop(2, 8'h0C);
    pop(2, 8'h0B);
    pop(2, 8'h0A);
    checkOutput(2, "lifoDrained", 0, 1'b0, 1'b1);

    push(2, 8'h0A);
    push(2, 8'h0B);
    pushPop(2, 8'h0D, 8'h0B);
    checkOutput(2, "lifoReplace", 2, 1'b0, 1'b0);
    pop(2, 8'h0D);
    pop(2, 8'h0A);
    checkOutput(2, "lifoReplDrained", 0, 1'b0, 1'b1);

    push(2, 8'h41);
    push(2, 8'h42);
    applyStimulus(2, 1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput(2, "clearLifo", 0, 1'b0, 1'b1);
    push(2, 8'h44);
    pop(2, 8'h44);
    checkOutput(2, "lifoPostClear", 0, 1'b0, 1'b1);

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      nVectors++;
      if (expQ[i].size() != 0) begin
        nMiscompares++;
        $display("[TB] FAIL pendingPops (dut %0d): got %0d unpopped, want 0", i, expQ[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
